ldl_rr_arbiter_lock: RTL and testbench
======================================

Name: ldl_rr_arbiter_lock

Overview:
- Registered round-robin arbiter with grant locking, sharing one resource among REQ_NUM requesters.
- Internally uses a masked lowest-index priority encode, rotated by a round-robin pointer.
- Emits the winner as one-hot and as a binary index.
- Sits in front of shared datapaths such as a bus port or memory bank. An optional hold limit keeps a single requester from starving the others.

Parameters:
- ID_WIDTH, 2, width of the binary grant index.
- REQ_NUM, 1<<ID_WIDTH, number of requesters.
- MAX_HOLD, 0, maximum cycles one grant may be held; 0 = unlimited.
- HOLD_WIDTH, 8, width of the hold counter; MAX_HOLD must be < 2^HOLD_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- en  input  1  arbitration enable; when 0, no new grant is issued.
- req  input  REQ_NUM  request per requester; held high for as long as the resource is wanted.
- gnt  output  REQ_NUM  one-hot grant, registered.
- gnt_id  output  ID_WIDTH  binary index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - Pointer ptr=0, hold counter cnt=0, state IDLE.
  - Takes effect immediately, including mid-grant. After reset release, arbitration resumes from ptr=0.
- Selection function SEL(r, p):
  - m = r & ~((1<<p)-1).
  - If m!=0, winner = lowest set bit of m; else winner = lowest set bit of r.
  - If r==0, there is no winner.
- All outputs are registered. A decision made in cycle t is visible from edge t+1 (1-cycle latency).
- State IDLE (gnt_valid=0):
  - If en=1 and |req: grant SEL(req, ptr), cnt=0, go to BUSY.
  - Otherwise stay in IDLE.
- State BUSY (owner k = gnt_id), evaluated each cycle:
  - Hold: req[k]=1 and not expired. Keep gnt, cnt++.
  - Release: req[k]=0.
    - ptr = (k+1) mod REQ_NUM.
    - If en=1 and |req, grant SEL(req, ptr) on the same edge (back-to-back, no dead cycle), cnt=0, stay in BUSY.
    - Otherwise gnt=0, go to IDLE.
  - Expire: MAX_HOLD!=0, req[k]=1 and cnt==MAX_HOLD-1.
    - timeout=1 for one cycle. ptr = (k+1) mod REQ_NUM.
    - Arbitrate with r = req & ~(1<<k), so k is excluded on this edge only.
    - If r!=0 and en=1, grant the winner and stay in BUSY. Otherwise gnt=0, go to IDLE.
    - k may win again at the next IDLE arbitration.
- A grant therefore lasts at most MAX_HOLD cycles.
- en=0 in BUSY: the current grant continues, and hold/expire rules still apply. On release or expire, go to IDLE with gnt=0; no re-grant until en=1.
- Requests from non-owners are ignored while a grant is held.
- A requester that drops req and re-asserts it in the same cycle cannot be observed; it is treated as a hold.
- gnt always has at most one bit set; gnt_id always matches gnt.
- cnt saturates at 2^HOLD_WIDTH-1 when MAX_HOLD=0.

Test Plan:
- Reset, then req=4'b0101 held, en=1 → cycle 1: gnt=0001, gnt_id=0. Drop req[0] → next edge gnt=0100, gnt_id=2, with no gap. Drop req[2] → gnt=0, gnt_valid=0.
- Fairness: req=4'b1111 and each owner drops req for one cycle after its grant → grant order 0,1,2,3,0.
- Wrap: ptr=3 after granting 2, req=4'b1001 → grant 3; after it releases, grant 0.
- MAX_HOLD=4, req=4'b0011 held constantly:
  - gnt_id=0 for exactly 4 cycles, then timeout pulses for 1 cycle and gnt_id=1.
  - After 4 more cycles, timeout pulses again and gnt_id=0.
  - Single requester req=4'b0001 held: 4 cycles of grant, 1 idle cycle, then re-grant to 0.
- en=0 while owner 1 holds with req=4'b1110: the grant persists. When req[1] drops, gnt=0 and stays 0 until en=1; then grant goes to 2.
- Assert rst_n=0 mid-grant (gnt_id=2) → outputs clear asynchronously. After release with req=4'b1100 → grant 2, because ptr is back at 0.

Source files
------------

// File: rtl/ldl_rr_arbiter_lock_if.sv
// Request/grant bundle between requesters and the round-robin lock arbiter.
// The master drives enable and requests; the slave (arbiter) returns the grant.
interface ldl_rr_arbiter_lock_if #(
    parameter int ID_WIDTH = 2,
    parameter int REQ_NUM  = 1 << ID_WIDTH
);
    logic                en;
    logic [REQ_NUM-1:0]  req;
    logic [REQ_NUM-1:0]  gnt;
    logic [ID_WIDTH-1:0] gnt_id;
    logic                gnt_valid;
    logic                timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/ldl_rr_arbiter_lock.sv
// Registered round-robin arbiter with grant locking and an optional hold limit.
// A grant stays with its owner while it keeps requesting, up to MAX_HOLD cycles.
module ldl_rr_arbiter_lock #(
    parameter int ID_WIDTH   = 2,
    parameter int REQ_NUM    = 1 << ID_WIDTH,
    parameter int MAX_HOLD   = 0,
    parameter int HOLD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ldl_rr_arbiter_lock_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int                    HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST   = HOLD_WIDTH'(HOLD_LAST_I);
    localparam logic                  HOLD_LIMIT  = (MAX_HOLD != 0);

    state_t              state_q, state_n;
    logic [REQ_NUM-1:0]  gnt_q, gnt_n;
    logic [ID_WIDTH-1:0] gnt_id_q, gnt_id_n;
    logic [ID_WIDTH-1:0] ptr_q, ptr_n;
    logic [HOLD_WIDTH-1:0] cnt_q, cnt_n;
    logic                timeout_q, timeout_n;

    logic                owner_req;
    logic                expire;
    logic [REQ_NUM-1:0]  cand;

    // Lowest set bit at or above the pointer; falls back to lowest set bit overall.
    function automatic logic [REQ_NUM-1:0] sel_onehot(
        input logic [REQ_NUM-1:0]  r,
        input logic [ID_WIDTH-1:0] p
    );
        logic [REQ_NUM-1:0] m;
        logic [REQ_NUM-1:0] pick;
        logic               found;
        m = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            m[i] = r[i] && (i >= int'(p));
        end
        if (m == '0) begin
            m = r;
        end
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (m[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [ID_WIDTH-1:0] onehot_to_id(input logic [REQ_NUM-1:0] oh);
        logic [ID_WIDTH-1:0] id;
        id = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (oh[i]) begin
                id = id | ID_WIDTH'(i);
            end
        end
        return id;
    endfunction

    function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] id);
        logic [ID_WIDTH-1:0] p;
        if (int'(id) >= REQ_NUM - 1) begin
            p = '0;
        end else begin
            p = id + 1'b1;
        end
        return p;
    endfunction

    function automatic logic [HOLD_WIDTH-1:0] cnt_inc(input logic [HOLD_WIDTH-1:0] c);
        logic [HOLD_WIDTH-1:0] n;
        if (c == '1) begin
            n = c;
        end else begin
            n = c + 1'b1;
        end
        return n;
    endfunction

    // State register: every output is taken straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            gnt_id_q  <= gnt_id_n;
            ptr_q     <= ptr_n;
            cnt_q     <= cnt_n;
            timeout_q <= timeout_n;
        end
    end

    // gnt is one-hot, so masking req with it yields the owner's own request.
    assign owner_req = |(gnt_q & bus.req);
    assign expire    = HOLD_LIMIT && owner_req && (cnt_q == HOLD_LAST);

    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        ptr_n     = ptr_q;
        cnt_n     = cnt_q;
        timeout_n = 1'b0;
        cand      = bus.req;
        case (state_q)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    gnt_n   = sel_onehot(bus.req, ptr_q);
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (owner_req && !expire) begin
                    cnt_n = cnt_inc(cnt_q);
                end else begin
                    // Release or expiry: rotate past the owner and try a same-edge handover.
                    ptr_n     = next_ptr(gnt_id_q);
                    timeout_n = expire;
                    cand      = expire ? (bus.req & ~gnt_q) : bus.req;
                    cnt_n     = '0;
                    if (bus.en && (|cand)) begin
                        gnt_n   = sel_onehot(cand, ptr_n);
                        state_n = BUSY;
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                gnt_n   = '0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        gnt_id_n = onehot_to_id(gnt_n);
    end

    always_comb begin
        bus.gnt       = gnt_q;
        bus.gnt_id    = gnt_id_q;
        bus.gnt_valid = |gnt_q;
        bus.timeout   = timeout_q;
    end

endmodule

// File: tb/tb_ldl_rr_arbiter_lock.sv
// Bench for ldl_rr_arbiter_lock: unlimited-hold and MAX_HOLD=4 instances share stimulus,
// each checked every cycle against a rotating-scan model, plus directed literal checks.
module tb_ldl_rr_arbiter_lock;

    localparam int N = 4;

    typedef struct {
        int owner;
        int ptr;
        int held;
        bit to;
    } mst_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;

    int total;
    int bad;

    mst_t ms0;
    mst_t ms4;

    ldl_rr_arbiter_lock_if #(.ID_WIDTH(2), .REQ_NUM(N)) bus0 ();
    ldl_rr_arbiter_lock_if #(.ID_WIDTH(2), .REQ_NUM(N)) bus4 ();

    assign bus0.en  = en;
    assign bus0.req = req;
    assign bus4.en  = en;
    assign bus4.req = req;

    ldl_rr_arbiter_lock #(.ID_WIDTH(2), .REQ_NUM(N), .MAX_HOLD(0), .HOLD_WIDTH(8)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    ldl_rr_arbiter_lock #(.ID_WIDTH(2), .REQ_NUM(N), .MAX_HOLD(4), .HOLD_WIDTH(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scan upward from p, wrapping around; first requester found wins.
    function automatic int sel(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    function automatic mst_t mnext(input mst_t s, input int maxh, input logic [N-1:0] r, input logic e);
        mst_t n;
        logic [N-1:0] rr;
        n    = s;
        n.to = 1'b0;
        if (s.owner < 0) begin
            if (e && r != 0) begin
                n.owner = sel(r, s.ptr);
                n.held  = 1;
            end
        end else if (!r[s.owner]) begin
            n.ptr = (s.owner + 1) % N;
            if (e && r != 0) begin
                n.owner = sel(r, n.ptr);
                n.held  = 1;
            end else begin
                n.owner = -1;
            end
        end else if (maxh != 0 && s.held >= maxh) begin
            n.to  = 1'b1;
            n.ptr = (s.owner + 1) % N;
            rr    = r;
            rr[s.owner] = 1'b0;
            if (e && rr != 0) begin
                n.owner = sel(rr, n.ptr);
                n.held  = 1;
            end else begin
                n.owner = -1;
            end
        end else begin
            n.held = s.held + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms0 <= '{owner: -1, ptr: 0, held: 0, to: 1'b0};
            ms4 <= '{owner: -1, ptr: 0, held: 0, to: 1'b0};
        end else begin
            ms0 <= mnext(ms0, 0, req, en);
            ms4 <= mnext(ms4, 4, req, en);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_gnt(input mst_t s);
        return (s.owner < 0) ? 32'd0 : (32'd1 << s.owner);
    endfunction

    function automatic logic [31:0] exp_id(input mst_t s);
        return (s.owner < 0) ? 32'd0 : 32'(s.owner);
    endfunction

    always @(negedge clk) begin
        check("m0_gnt", 32'(bus0.gnt), exp_gnt(ms0));
        check("m0_id", 32'(bus0.gnt_id), exp_id(ms0));
        check("m0_valid", 32'(bus0.gnt_valid), 32'(ms0.owner >= 0));
        check("m0_timeout", 32'(bus0.timeout), 32'(ms0.to));
        check("m4_gnt", 32'(bus4.gnt), exp_gnt(ms4));
        check("m4_id", 32'(bus4.gnt_id), exp_id(ms4));
        check("m4_valid", 32'(bus4.gnt_valid), 32'(ms4.owner >= 0));
        check("m4_timeout", 32'(bus4.timeout), 32'(ms4.to));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        en    = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        #2;
        check("rst_gnt", 32'(bus0.gnt), 32'd0);
        check("rst_valid", 32'(bus0.gnt_valid), 32'd0);
        check("rst_timeout", 32'(bus4.timeout), 32'd0);
        cyc();
        rst_n = 1'b1;

        // Back-to-back handover with no dead cycle
        en = 1'b1; req = 4'b0101; cyc();
        check("b2b_first", 32'(bus0.gnt), 32'b0001);
        check("b2b_first_id", 32'(bus0.gnt_id), 32'd0);
        req = 4'b0100; cyc();
        check("b2b_second", 32'(bus0.gnt), 32'b0100);
        check("b2b_second_id", 32'(bus0.gnt_id), 32'd2);
        req = 4'b0000; cyc();
        check("b2b_idle", 32'(bus0.gnt), 32'd0);
        check("b2b_idle_valid", 32'(bus0.gnt_valid), 32'd0);

        // Fairness: each owner drops its request for one cycle
        do_reset();
        en = 1'b1; req = 4'b1111; cyc();
        check("fair_0", 32'(bus0.gnt_id), 32'd0);
        req = 4'b1110; cyc();
        check("fair_1", 32'(bus0.gnt_id), 32'd1);
        req = 4'b1101; cyc();
        check("fair_2", 32'(bus0.gnt_id), 32'd2);
        req = 4'b1011; cyc();
        check("fair_3", 32'(bus0.gnt_id), 32'd3);
        req = 4'b0111; cyc();
        check("fair_wrap0", 32'(bus0.gnt_id), 32'd0);

        // Pointer wrap from 3 back to 0
        do_reset();
        en = 1'b1; req = 4'b0100; cyc();
        check("wrap_g2", 32'(bus0.gnt), 32'b0100);
        req = 4'b1001; cyc();
        check("wrap_g3", 32'(bus0.gnt), 32'b1000);
        req = 4'b0001; cyc();
        check("wrap_g0", 32'(bus0.gnt), 32'b0001);
        req = 4'b0000; cyc();

        // Hold limit on the MAX_HOLD=4 instance
        do_reset();
        en = 1'b1; req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("mh_own0", 32'(bus4.gnt_id), 32'd0);
            check("mh_noto0", 32'(bus4.timeout), 32'd0);
        end
        cyc();
        check("mh_to1", 32'(bus4.timeout), 32'd1);
        check("mh_own1", 32'(bus4.gnt_id), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mh_hold1", 32'(bus4.gnt_id), 32'd1);
            check("mh_noto1", 32'(bus4.timeout), 32'd0);
        end
        cyc();
        check("mh_to2", 32'(bus4.timeout), 32'd1);
        check("mh_back0", 32'(bus4.gnt_id), 32'd0);
        check("mh_unlim", 32'(bus0.gnt_id), 32'd0);

        // Single requester: four cycles, one idle cycle, re-grant
        do_reset();
        en = 1'b1; req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("single_gnt", 32'(bus4.gnt), 32'b0001);
        end
        cyc();
        check("single_gap", 32'(bus4.gnt_valid), 32'd0);
        check("single_to", 32'(bus4.timeout), 32'd1);
        cyc();
        check("single_regnt", 32'(bus4.gnt), 32'b0001);

        // en=0 keeps the current grant but blocks new ones
        do_reset();
        en = 1'b1; req = 4'b1110; cyc();
        check("en_g1", 32'(bus0.gnt), 32'b0010);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("en_keep", 32'(bus0.gnt), 32'b0010);
        end
        req = 4'b1100; cyc();
        check("en_rel", 32'(bus0.gnt), 32'd0);
        cyc();
        check("en_blocked", 32'(bus0.gnt_valid), 32'd0);
        en = 1'b1; cyc();
        check("en_g2", 32'(bus0.gnt), 32'b0100);

        // Asynchronous reset mid-grant, then restart from ptr=0
        rst_n = 1'b0; #1;
        check("arst_gnt", 32'(bus0.gnt), 32'd0);
        check("arst_id", 32'(bus0.gnt_id), 32'd0);
        check("arst_valid", 32'(bus0.gnt_valid), 32'd0);
        cyc();
        rst_n = 1'b1; req = 4'b1100; en = 1'b1; cyc();
        check("arst_regnt", 32'(bus0.gnt_id), 32'd2);

        // Random traffic: sticky requests with occasional toggles
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req = req ^ N'($urandom_range(0, 15) & $urandom_range(0, 15));
            en  = ($urandom_range(0, 9) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
